id_ex_control: RTL and testbench
================================

# id_ex_control

Main control decoder and ID/EX control pipeline register for the MIPS pipeline. Decodes the ID-stage opcode into the 3-bit ALU operation class consumed by the EX-stage ALU control decoder, plus the datapath and memory control bits, and registers them into EX. Detects load-use hazards and inserts a single-cycle bubble. Honours branch flushes from EX.

## Interface
Parameters:
- none.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_opcode  in  6  instr[31:26].
- id_funct  in  6  instr[5:0]; passed through for EX ALU control.
- id_rs, id_rt, id_rd  in  5 each  register specifiers.
- flush  in  1  branch taken in EX; kill the instruction in ID.
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- ex_valid  out  1  EX holds a real instruction.
- ex_aluop  out  3  ALU operation class.
- ex_funct  out  6  registered id_funct.
- ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_branch, ex_branch_ne  out  1 each.
- ex_rs, ex_rt  out  5 each  registered specifiers, for forwarding.
- ex_wreg  out  5  destination register: rd for R-type, rt otherwise.
- ex_illegal  out  1  one-cycle flag: a valid instruction had an unknown opcode.

## Operation
- Decode (id_valid=1):
  - R-type 000000: aluop 010, reg_write, wreg=rd.
  - lw 100011: aluop 000, alu_src, mem_read, mem_to_reg, reg_write.
  - sw 101011: aluop 000, alu_src, mem_write.
  - beq 000100: aluop 001, branch.
  - bne 000101: aluop 001, branch, branch_ne.
  - addi 001000: aluop 011, alu_src, reg_write.
  - andi 001100: aluop 100, alu_src, reg_write.
  - ori 001101: aluop 101, alu_src, reg_write.
- Unknown opcode: bubble into EX, ex_illegal=1 for one cycle.
- Bubble: ex_valid=0 and all control bits and aluop are 0. ex_funct, ex_rs, ex_rt and ex_wreg are don't-care but are driven to 0.
- reg_write is forced to 0 when the selected wreg equals 0.
- Load-use hazard:
  - stall=1 when ex_valid, ex_mem_read and ex_wreg≠0 all hold, and ex_wreg equals id_rs, or ex_wreg equals id_rt for R-type, sw, beq or bne.
  - id_valid must be 1 for stall to assert.
- Priority at the clock edge: reset > flush > stall > normal load.
  - flush: bubble into EX; stall forced to 0.
  - stall: bubble into EX; the instruction stays in ID.
  - id_valid=0: bubble into EX.

## Timing
- Reset: every ex_* output is 0 one edge after rst_n is sampled low. stall is 0 while EX holds a bubble, which covers reset.
- Latency: ID inputs appear on ex_* one cycle after the rising edge.
- A load-use stall lasts exactly one cycle. The next cycle EX holds the bubble, so stall deasserts and the ID instruction advances.
- Back-to-back loads with a dependency each produce their own single-cycle stall.
- flush and stall in the same cycle: flush wins, one bubble, stall=0.
- Reset asserted mid-stall: stall state is cleared and the pipeline restarts clean.

## Configuration
- LOAD_USE_STALL_EN:
  - Defined: hazard detection and bubble insertion as above.
  - Undefined: stall is tied to 0 and no hazard bubbles are inserted. flush and illegal-opcode bubbles still occur. Software scheduling is then responsible for load-use spacing.

## Structure
- Shared package mips_ctrl_pkg holds:
  - Opcode constants.
  - ALU operation class encodings (LWSW=000, BRANCH=001, RTYPE=010, ADDI=011, ANDI=100, ORI=101).
  - The packed control-bundle typedef.
- Sub-module main_decoder: purely combinational opcode to control-bundle plus illegal flag. The ID/EX register, priority logic and hazard compare stay in id_ex_control.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with id_valid=1 and lw → all ex_* are 0 and stall=0. After release, lw appears one cycle later with aluop=000 and mem_read=1.
- Decode sweep: each of the eight opcodes in turn → correct aluop and control bits one cycle later. R-type with rd=0 → reg_write=0.
- Load-use: lw $5 followed by add $3,$5,$2 → stall=1 for one cycle and an EX bubble. add reaches EX on the following cycle with stall=0. addi $3,$5,1 after lw $5 also stalls. lw $5 followed by addi $5,$0,1 (rt only as destination) → no stall.
- Flush with stall: lw $5 in EX, flush=1, dependent instruction in ID → bubble, stall=0, and the next load proceeds normally.
- Illegal opcode 111111 → bubble and ex_illegal=1 for exactly one cycle.
- Build with LOAD_USE_STALL_EN undefined → the lw/add pair produces stall=0 and no bubble.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared opcode constants, ALU operation classes and control bundle for the
// MIPS ID/EX control path.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [2:0] ALUOP_LWSW   = 3'b000;
  localparam logic [2:0] ALUOP_BRANCH = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE  = 3'b010;
  localparam logic [2:0] ALUOP_ADDI   = 3'b011;
  localparam logic [2:0] ALUOP_ANDI   = 3'b100;
  localparam logic [2:0] ALUOP_ORI    = 3'b101;

  typedef struct packed {
    logic [2:0] aluop;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic       branch_ne;
  } ctrl_t;

  // Instructions whose rt is a source operand, so rt matters for load-use.
  function automatic logic reads_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) ||
           (opcode == OP_BEQ)   || (opcode == OP_BNE);
  endfunction

endpackage

// File: rtl/main_decoder.sv
// Combinational main decoder: ID opcode to control bundle plus illegal flag.
module main_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.aluop     = ALUOP_RTYPE;
        ctrl.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl.aluop      = ALUOP_LWSW;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      OP_SW: begin
        ctrl.aluop     = ALUOP_LWSW;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl.aluop  = ALUOP_BRANCH;
        ctrl.branch = 1'b1;
      end
      OP_BNE: begin
        ctrl.aluop     = ALUOP_BRANCH;
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        ctrl.aluop     = (opcode == OP_ADDI) ? ALUOP_ADDI :
                         (opcode == OP_ANDI) ? ALUOP_ANDI : ALUOP_ORI;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_control.sv
// ID/EX control pipeline register with load-use hazard bubble and flush.
// Define LOAD_USE_STALL_EN to enable hardware load-use stalling.
module id_ex_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [5:0] id_opcode,
  input  logic [5:0] id_funct,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       flush,
  output logic       stall,
  output logic       ex_valid,
  output logic [2:0] ex_aluop,
  output logic [5:0] ex_funct,
  output logic       ex_alu_src,
  output logic       ex_mem_read,
  output logic       ex_mem_write,
  output logic       ex_mem_to_reg,
  output logic       ex_reg_write,
  output logic       ex_branch,
  output logic       ex_branch_ne,
  output logic [4:0] ex_rs,
  output logic [4:0] ex_rt,
  output logic [4:0] ex_wreg,
  output logic       ex_illegal
);

  ctrl_t      id_ctrl;
  logic       id_illegal;
  logic [4:0] id_wreg;

  ctrl_t      ex_ctrl_d,    ex_ctrl_q;
  logic       ex_valid_d,   ex_valid_q;
  logic       ex_illegal_d, ex_illegal_q;
  logic [5:0] ex_funct_d,   ex_funct_q;
  logic [4:0] ex_rs_d,      ex_rs_q;
  logic [4:0] ex_rt_d,      ex_rt_q;
  logic [4:0] ex_wreg_d,    ex_wreg_q;

  main_decoder u_main_decoder (
    .opcode  (id_opcode),
    .ctrl    (id_ctrl),
    .illegal (id_illegal)
  );

  assign id_wreg = (id_opcode == OP_RTYPE) ? id_rd : id_rt;

`ifdef LOAD_USE_STALL_EN
  logic load_use;

  always_comb begin
    load_use = id_valid && ex_valid_q && ex_ctrl_q.mem_read && (ex_wreg_q != 5'd0) &&
               ((ex_wreg_q == id_rs) || (reads_rt(id_opcode) && (ex_wreg_q == id_rt)));
  end

  // A flush kills the ID instruction anyway, so holding it would be pointless.
  assign stall = load_use && !flush;
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    ex_valid_d   = 1'b0;
    ex_ctrl_d    = '0;
    ex_illegal_d = 1'b0;
    ex_funct_d   = '0;
    ex_rs_d      = '0;
    ex_rt_d      = '0;
    ex_wreg_d    = '0;
    if (id_valid && !flush && !stall) begin
      if (id_illegal) begin
        ex_illegal_d = 1'b1;
      end else begin
        ex_valid_d           = 1'b1;
        ex_ctrl_d            = id_ctrl;
        ex_ctrl_d.reg_write  = id_ctrl.reg_write && (id_wreg != 5'd0);
        ex_funct_d           = id_funct;
        ex_rs_d              = id_rs;
        ex_rt_d              = id_rt;
        ex_wreg_d            = id_wreg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= '0;
      ex_illegal_q <= 1'b0;
      ex_funct_q   <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_wreg_q    <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_illegal_q <= ex_illegal_d;
      ex_funct_q   <= ex_funct_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_wreg_q    <= ex_wreg_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_aluop      = ex_ctrl_q.aluop;
  assign ex_funct      = ex_funct_q;
  assign ex_alu_src    = ex_ctrl_q.alu_src;
  assign ex_mem_read   = ex_ctrl_q.mem_read;
  assign ex_mem_write  = ex_ctrl_q.mem_write;
  assign ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
  assign ex_reg_write  = ex_ctrl_q.reg_write;
  assign ex_branch     = ex_ctrl_q.branch;
  assign ex_branch_ne  = ex_ctrl_q.branch_ne;
  assign ex_rs         = ex_rs_q;
  assign ex_rt         = ex_rt_q;
  assign ex_wreg       = ex_wreg_q;
  assign ex_illegal    = ex_illegal_q;

endmodule

// File: tb/tb_id_ex_control.sv
// Scoreboard bench for id_ex_control; expectations adapt to LOAD_USE_STALL_EN.
module tb_id_ex_control;

  typedef struct packed {
    logic       valid;
    logic [2:0] aluop;
    logic [5:0] funct;
    logic [6:0] ctl;     // alu_src,mem_read,mem_write,mem_to_reg,reg_write,branch,branch_ne
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wreg;
    logic       illegal;
  } ex_t;

  typedef struct packed {
    logic       chk_stall;
    logic       stall;
    ex_t        ex;
  } exp_t;

`ifdef LOAD_USE_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101;
  localparam logic [6:0] C_LW = 7'b1101100, C_SW = 7'b1010000, C_R = 7'b0000100;
  localparam logic [6:0] C_IMM = 7'b1000100, C_BEQ = 7'b0000010, C_BNE = 7'b0000011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [5:0] id_opcode, id_funct;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       flush;
  logic       stall, ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic       ex_reg_write, ex_branch, ex_branch_ne, ex_illegal;
  logic [2:0] ex_aluop;
  logic [5:0] ex_funct;
  logic [4:0] ex_rs, ex_rt, ex_wreg;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  id_ex_control dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_funct(ex_funct),
    .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_branch(ex_branch),
    .ex_branch_ne(ex_branch_ne), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
    .ex_illegal(ex_illegal)
  );

  function automatic ex_t mk(input logic [2:0] aluop, input logic [6:0] ctl,
                             input logic [5:0] funct, input logic [4:0] rs,
                             input logic [4:0] rt, input logic [4:0] wreg);
    ex_t e;
    e.valid = 1'b1; e.aluop = aluop; e.funct = funct; e.ctl = ctl;
    e.rs = rs; e.rt = rt; e.wreg = wreg; e.illegal = 1'b0;
    return e;
  endfunction

  task automatic applyStimulus(input logic rst, input logic valid, input logic [5:0] op,
                               input logic [5:0] funct, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd, input logic fl,
                               input logic chk, input logic stall_exp, input ex_t ex_exp);
    exp_t e;
    @(negedge clk);
    rst_n = rst; id_valid = valid; id_opcode = op; id_funct = funct;
    id_rs = rs; id_rt = rt; id_rd = rd; flush = fl;
    e.chk_stall = chk; e.stall = stall_exp; e.ex = ex_exp;
    exp_q.push_back(e);
  endtask

  // Monitor: stall sampled just before the edge, EX outputs just after it.
  initial begin
    logic stall_snap;
    ex_t  got;
    exp_t e;
    forever begin
      @(negedge clk);
      #4 stall_snap = stall;
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        got = {ex_valid, ex_aluop, ex_funct,
               {ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write,
                ex_branch, ex_branch_ne}, ex_rs, ex_rt, ex_wreg, ex_illegal};
        if (e.chk_stall) begin
          n_vec++;
          if (stall_snap !== e.stall) begin
            n_fail++;
            $display("[TB] FAIL stall @%0t: got %b expected %b", $time, stall_snap, e.stall);
          end
        end
        n_vec++;
        if (got !== e.ex) begin
          n_fail++;
          $display("[TB] FAIL ex_bundle @%0t: got %h expected %h", $time, got, e.ex);
        end
      end
    end
  end

  initial begin
    ex_t z;
    z = '0;
    rst_n = 1'b0; id_valid = 1'b0; id_opcode = '0; id_funct = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; flush = 1'b0;

    // Reset held with a lw presented
    applyStimulus(0, 1, LW, 6'h00, 5'd1, 5'd5, 5'd0, 0, 0, 0, z);
    applyStimulus(0, 1, LW, 6'h00, 5'd1, 5'd5, 5'd0, 0, 1, 0, z);
    applyStimulus(1, 1, LW, 6'h00, 5'd1, 5'd5, 5'd0, 0, 1, 0, mk(3'b000, C_LW, 6'h00, 5'd1, 5'd5, 5'd5));
    // lw $5 ; add $3,$5,$2
    applyStimulus(1, 1, RT, 6'h20, 5'd5, 5'd2, 5'd3, 0, 1, STALL_EN,
                  STALL_EN ? z : mk(3'b010, C_R, 6'h20, 5'd5, 5'd2, 5'd3));
    applyStimulus(1, 1, RT, 6'h20, 5'd5, 5'd2, 5'd3, 0, 1, 0, mk(3'b010, C_R, 6'h20, 5'd5, 5'd2, 5'd3));
    // lw $5 ; addi $3,$5,1
    applyStimulus(1, 1, LW, 6'h04, 5'd0, 5'd5, 5'd0, 0, 1, 0, mk(3'b000, C_LW, 6'h04, 5'd0, 5'd5, 5'd5));
    applyStimulus(1, 1, ADDI, 6'h01, 5'd5, 5'd3, 5'd0, 0, 1, STALL_EN,
                  STALL_EN ? z : mk(3'b011, C_IMM, 6'h01, 5'd5, 5'd3, 5'd3));
    applyStimulus(1, 1, ADDI, 6'h01, 5'd5, 5'd3, 5'd0, 0, 1, 0, mk(3'b011, C_IMM, 6'h01, 5'd5, 5'd3, 5'd3));
    // lw $5 ; addi $5,$0,1 : rt only written, no hazard
    applyStimulus(1, 1, LW, 6'h04, 5'd0, 5'd5, 5'd0, 0, 1, 0, mk(3'b000, C_LW, 6'h04, 5'd0, 5'd5, 5'd5));
    applyStimulus(1, 1, ADDI, 6'h01, 5'd0, 5'd5, 5'd0, 0, 1, 0, mk(3'b011, C_IMM, 6'h01, 5'd0, 5'd5, 5'd5));
    // Decode sweep
    applyStimulus(1, 1, SW, 6'h08, 5'd2, 5'd4, 5'd0, 0, 1, 0, mk(3'b000, C_SW, 6'h08, 5'd2, 5'd4, 5'd4));
    applyStimulus(1, 1, BEQ, 6'h03, 5'd1, 5'd2, 5'd0, 0, 1, 0, mk(3'b001, C_BEQ, 6'h03, 5'd1, 5'd2, 5'd2));
    applyStimulus(1, 1, BNE, 6'h3f, 5'd3, 5'd4, 5'd0, 0, 1, 0, mk(3'b001, C_BNE, 6'h3f, 5'd3, 5'd4, 5'd4));
    applyStimulus(1, 1, ANDI, 6'h0f, 5'd6, 5'd7, 5'd0, 0, 1, 0, mk(3'b100, C_IMM, 6'h0f, 5'd6, 5'd7, 5'd7));
    applyStimulus(1, 1, ORI, 6'h10, 5'd8, 5'd9, 5'd0, 0, 1, 0, mk(3'b101, C_IMM, 6'h10, 5'd8, 5'd9, 5'd9));
    applyStimulus(1, 1, RT, 6'h20, 5'd1, 5'd2, 5'd0, 0, 1, 0, mk(3'b010, 7'b0000000, 6'h20, 5'd1, 5'd2, 5'd0));
    applyStimulus(1, 1, ADDI, 6'h02, 5'd1, 5'd0, 5'd0, 0, 1, 0, mk(3'b011, 7'b1000000, 6'h02, 5'd1, 5'd0, 5'd0));
    // Flush beats a pending load-use stall
    applyStimulus(1, 1, LW, 6'h00, 5'd0, 5'd5, 5'd0, 0, 1, 0, mk(3'b000, C_LW, 6'h00, 5'd0, 5'd5, 5'd5));
    applyStimulus(1, 1, RT, 6'h20, 5'd5, 5'd2, 5'd3, 1, 1, 0, z);
    applyStimulus(1, 1, LW, 6'h00, 5'd5, 5'd6, 5'd0, 0, 1, 0, mk(3'b000, C_LW, 6'h00, 5'd5, 5'd6, 5'd6));
    // Back-to-back dependent loads, then sw depending through rt
    applyStimulus(1, 1, LW, 6'h00, 5'd6, 5'd7, 5'd0, 0, 1, STALL_EN,
                  STALL_EN ? z : mk(3'b000, C_LW, 6'h00, 5'd6, 5'd7, 5'd7));
    applyStimulus(1, 1, LW, 6'h00, 5'd6, 5'd7, 5'd0, 0, 1, 0, mk(3'b000, C_LW, 6'h00, 5'd6, 5'd7, 5'd7));
    applyStimulus(1, 1, SW, 6'h00, 5'd0, 5'd7, 5'd0, 0, 1, STALL_EN,
                  STALL_EN ? z : mk(3'b000, C_SW, 6'h00, 5'd0, 5'd7, 5'd7));
    applyStimulus(1, 0, SW, 6'h00, 5'd0, 5'd7, 5'd0, 0, 1, 0, z);
    // id_valid=0 suppresses stall even with a matching rs
    applyStimulus(1, 1, LW, 6'h00, 5'd0, 5'd5, 5'd0, 0, 1, 0, mk(3'b000, C_LW, 6'h00, 5'd0, 5'd5, 5'd5));
    applyStimulus(1, 0, RT, 6'h20, 5'd5, 5'd2, 5'd3, 0, 1, 0, z);
    // Illegal opcode flags for exactly one cycle
    applyStimulus(1, 1, 6'b111111, 6'h00, 5'd0, 5'd0, 5'd0, 0, 1, 0, '{default: 1'b0, illegal: 1'b1});
    applyStimulus(1, 1, ORI, 6'h01, 5'd1, 5'd2, 5'd0, 0, 1, 0, mk(3'b101, C_IMM, 6'h01, 5'd1, 5'd2, 5'd2));
    // Reset mid-stall restarts clean
    applyStimulus(1, 1, LW, 6'h00, 5'd0, 5'd5, 5'd0, 0, 1, 0, mk(3'b000, C_LW, 6'h00, 5'd0, 5'd5, 5'd5));
    applyStimulus(0, 1, RT, 6'h20, 5'd5, 5'd2, 5'd3, 0, 0, 0, z);
    applyStimulus(1, 1, RT, 6'h20, 5'd5, 5'd2, 5'd3, 0, 1, 0, mk(3'b010, C_R, 6'h20, 5'd5, 5'd2, 5'd3));

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
